signal_arbiter: RTL

SIGNAL_ARBITER -- requirements
Module: signal_arbiter

---
 rtl/safety_pkg.sv | 28 ++
 rtl/rise_detect.sv | 32 +++
 rtl/signal_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/safety_pkg.sv
// safety_pkg
//   Types and helpers shared by the turn-signal / hazard arbiter.
//   mode_t     : operating mode, also driven out as the 2-bit mode port.
//   isTurn     : true in the single-side blinking modes (auto-cancel applies).
//   drivesLeft : true in the modes that blink the left lamp.
//   drivesRight: true in the modes that blink the right lamp.
package safety_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  function automatic logic isTurn(input mode_t m);
    return (m == LEFT) || (m == RIGHT);
  endfunction

  function automatic logic drivesLeft(input mode_t m);
    return (m == LEFT) || (m == HAZARD);
  endfunction

  function automatic logic drivesRight(input mode_t m);
    return (m == RIGHT) || (m == HAZARD);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect
//   Registered rising-edge detector for one debounced button level.
//   A rise sampled at clock edge N produces a one-cycle pulse that the
//   consumer acts on at edge N+1.
//   Ports:
//     CLOCK_50 : clock, rising edge
//     reset_n  : asynchronous active-low reset
//     level    : debounced button level
//     rise     : one-cycle registered pulse per low-to-high transition
module rise_detect (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  // History is kept as "was low last cycle" so that its reset value of 0
  // makes a button held high through reset release look like no edge; the
  // button must be seen low before a rise can be reported.
  logic wasLow;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wasLow <= 1'b0;
      rise   <= 1'b0;
    end else begin
      wasLow <= ~level;
      rise   <= level & wasLow;
    end
  end

endmodule

// File: rtl/signal_arbiter.sv
// signal_arbiter
//   Turn-signal / hazard arbiter. Button rises select IDLE, LEFT, RIGHT or
//   HAZARD; the selected lamps blink with a fixed half period, single-side
//   modes cancel themselves after CANCEL_BLINKS full periods, and every entry
//   into a blinking mode requests a horn chirp of CHIRP_LEN cycles.
//   Ports:
//     CLOCK_50   : clock, rising edge
//     reset_n    : asynchronous active-low reset
//     left_req   : debounced left button level
//     right_req  : debounced right button level
//     hazard_req : debounced hazard button level
//     left_lamp  : registered left lamp drive
//     right_lamp : registered right lamp drive
//     mode       : registered mode (0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD)
//     chirp      : registered horn-request pulse
module signal_arbiter
  import safety_pkg::*;
#(
  parameter int HALF_PERIOD   = 25_000_000,
  parameter int CANCEL_BLINKS = 20,
  parameter int CHIRP_LEN     = 2_500_000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  output logic       left_lamp,
  output logic       right_lamp,
  output logic [1:0] mode,
  output logic       chirp
);

  localparam int PHASE_W = $clog2(2 * HALF_PERIOD);
  localparam int BLINK_W = $clog2(CANCEL_BLINKS + 1);
  localparam int CHIRP_W = $clog2(CHIRP_LEN + 1);

  localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(2 * HALF_PERIOD - 1);
  localparam logic [PHASE_W-1:0] PHASE_ON_END = PHASE_W'(HALF_PERIOD);
  localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(CANCEL_BLINKS - 1);
  localparam logic [CHIRP_W-1:0] CHIRP_FULL   = CHIRP_W'(CHIRP_LEN);

  logic leftRise, rightRise, hazardRise;

  mode_t              state, nextState;
  logic [PHASE_W-1:0] phase, nextPhase;
  logic [BLINK_W-1:0] blinks;
  logic [CHIRP_W-1:0] chirpCnt, nextChirpCnt;
  logic               phaseWrap, autoCancel, stateChange;

  rise_detect u_leftRise (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .level    (left_req),
    .rise     (leftRise)
  );

  rise_detect u_rightRise (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .level    (right_req),
    .rise     (rightRise)
  );

  rise_detect u_hazardRise (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .level    (hazard_req),
    .rise     (hazardRise)
  );

  assign phaseWrap  = (phase == PHASE_LAST);
  // The wrap that would complete the last allowed blink ends the mode.
  assign autoCancel = isTurn(state) && phaseWrap && (blinks == BLINK_LAST);

  // Hazard has absolute priority; a simultaneous left+right press is
  // treated as no press, so auto-cancel can still take effect that cycle.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    if (hazardRise) begin
      nextState = (state == HAZARD) ? IDLE : HAZARD;
    end else if (state != HAZARD && leftRise && !rightRise) begin
      nextState = (state == LEFT) ? IDLE : LEFT;
    end else if (state != HAZARD && rightRise && !leftRise) begin
      nextState = (state == RIGHT) ? IDLE : RIGHT;
    end else if (autoCancel) begin
      nextState = IDLE;
    end
  end

  assign stateChange = (nextState != state);

  // Lamps and chirp are registered from the next-cycle values so they move
  // in the same cycle as mode.
  always_comb begin
    nextPhase = phase + PHASE_W'(1);
    if (stateChange || phaseWrap) begin
      nextPhase = '0;
    end
  end

  // Entering IDLE neither starts nor truncates a running chirp.
  always_comb begin
    nextChirpCnt = chirpCnt;
    if (stateChange && nextState != IDLE) begin
      nextChirpCnt = CHIRP_FULL;
    end else if (chirpCnt != '0) begin
      nextChirpCnt = chirpCnt - CHIRP_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase      <= '0;
      blinks     <= '0;
      chirpCnt   <= '0;
      chirp      <= 1'b0;
      left_lamp  <= 1'b0;
      right_lamp <= 1'b0;
    end else begin
      state    <= nextState;
      phase    <= nextPhase;
      chirpCnt <= nextChirpCnt;
      chirp    <= (nextChirpCnt != '0);

      if (stateChange) begin
        blinks <= '0;
      end else if (isTurn(state) && phaseWrap) begin
        blinks <= blinks + BLINK_W'(1);
      end

      left_lamp  <= drivesLeft(nextState)  && (nextPhase < PHASE_ON_END);
      right_lamp <= drivesRight(nextState) && (nextPhase < PHASE_ON_END);
    end
  end

  assign mode = state;

endmodule
